// File: rtl/usb_pkg.sv
// Shared types and constants for the full-speed USB receive path.
package usb_pkg;

    // Encoded as {D+, D-} so a synchronized line pair maps onto it bit for bit.
    typedef enum logic [1:0] {
        LS_SE0 = 2'b00,
        LS_K   = 2'b01,
        LS_J   = 2'b10,
        LS_SE1 = 2'b11
    } line_state_t;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SYNC  = 3'd1,
        DATA  = 3'd2,
        EOP   = 3'd3,
        ERROR = 3'd4
    } rx_state_t;

    localparam logic [7:0]  SYNC_PATTERN = 8'h80;
    localparam int unsigned STUFF_LIMIT  = 6;

    // NRZI: an unchanged line state carries a 1.
    function automatic logic nrzi_bit(input line_state_t cur, input line_state_t prev);
        return (cur == prev);
    endfunction

endpackage

// File: rtl/usb_rx_bit_timer.sv
// Line synchronizer and bit-period timer; sample_en marks mid-bit, re-aligned on every line edge.
module usb_rx_bit_timer
    import usb_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 8
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic        dplus,
    input  logic        dminus,
    input  logic        resync_en,
    output line_state_t line,
    output line_state_t line_prev,
    output logic        sample_en
);

    localparam int unsigned     CNT_W      = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_MAX    = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_SAMPLE = CNT_W'(CLKS_PER_BIT / 2 - 1);

    logic [1:0]       dp_sync;
    logic [1:0]       dm_sync;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;

    assign line = line_state_t'({dp_sync[1], dm_sync[1]});

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            dp_sync <= 2'b00;
            dm_sync <= 2'b00;
        end else begin
            dp_sync <= {dp_sync[0], dplus};
            dm_sync <= {dm_sync[0], dminus};
        end
    end

    always_comb begin
        cnt_next = cnt + 1'b1;
        if (resync_en && (line != line_prev)) begin
            cnt_next = '0;
        end else if (cnt == CNT_MAX) begin
            cnt_next = '0;
        end
    end

    // sample_en is registered off cnt_next so it is high exactly while cnt sits at mid-bit.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            line_prev <= LS_SE0;
            cnt       <= '0;
            sample_en <= 1'b0;
        end else begin
            line_prev <= line;
            cnt       <= cnt_next;
            sample_en <= (cnt_next == CNT_SAMPLE);
        end
    end

endmodule

// File: rtl/usb_rx_decoder.sv
// Full-speed USB receive front end: SYNC detect, NRZI decode, unstuffing, byte assembly, EOP.
module usb_rx_decoder
    import usb_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 8
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       dplus_in,
    input  logic       dminus_in,
    output logic [7:0] rx_data,
    output logic       rx_data_valid,
    output logic       rx_packet_start,
    output logic       rx_packet_done,
    output logic       rx_error,
    output logic       rx_active
);

    localparam int unsigned      CNT_W    = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] J_HOLD   = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]       ONES_MAX = 3'(STUFF_LIMIT);

    rx_state_t        state, state_next;
    line_state_t      line, line_prev;
    line_state_t      nrzi_prev, nrzi_prev_next;
    logic             sample_en;
    logic             bit_c;
    logic             byte_done_c;
    logic [7:0]       shift, shift_next;
    logic [2:0]       bit_cnt, bit_cnt_next;
    logic [2:0]       ones_cnt, ones_cnt_next;
    logic             eop_seen, eop_seen_next;
    logic [CNT_W-1:0] j_cnt, j_cnt_next;
    logic [7:0]       data_next;
    logic             valid_next, start_next, done_next, error_next, active_next;

    usb_rx_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_bit_timer (
        .clk       (clk),
        .n_rst     (n_rst),
        .dplus     (dplus_in),
        .dminus    (dminus_in),
        .resync_en (state != ERROR),
        .line      (line),
        .line_prev (line_prev),
        .sample_en (sample_en)
    );

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next     = state;
        nrzi_prev_next = nrzi_prev;
        shift_next     = shift;
        bit_cnt_next   = bit_cnt;
        ones_cnt_next  = ones_cnt;
        eop_seen_next  = eop_seen;
        j_cnt_next     = j_cnt;
        byte_done_c    = 1'b0;
        bit_c          = nrzi_bit(line, nrzi_prev);
        case (state)
            IDLE: begin
                if (line_prev == LS_J && line == LS_K) begin
                    state_next     = SYNC;
                    nrzi_prev_next = LS_J;
                    bit_cnt_next   = '0;
                end
            end
            SYNC: begin
                if (sample_en) begin
                    nrzi_prev_next = line;
                    if (line == LS_SE0 || line == LS_SE1 || bit_c != SYNC_PATTERN[bit_cnt]) begin
                        state_next = ERROR;
                    end else if (bit_cnt == 3'd7) begin
                        state_next    = DATA;
                        bit_cnt_next  = '0;
                        ones_cnt_next = 3'd1;
                        shift_next    = '0;
                    end else begin
                        bit_cnt_next = bit_cnt + 3'd1;
                    end
                end
            end
            DATA: begin
                if (sample_en) begin
                    nrzi_prev_next = line;
                    if (line == LS_SE1) begin
                        state_next = ERROR;
                    end else if (line == LS_SE0) begin
                        state_next    = (bit_cnt == 3'd0) ? EOP : ERROR;
                        eop_seen_next = 1'b0;
                    end else if (ones_cnt == ONES_MAX) begin
                        // Stuffed bit: must be 0, never enters the byte.
                        if (bit_c) state_next = ERROR;
                        ones_cnt_next = '0;
                    end else begin
                        shift_next    = {bit_c, shift[7:1]};
                        ones_cnt_next = bit_c ? ones_cnt + 3'd1 : 3'd0;
                        bit_cnt_next  = bit_cnt + 3'd1;
                        byte_done_c   = (bit_cnt == 3'd7);
                    end
                end
            end
            EOP: begin
                if (sample_en) begin
                    if (line == LS_J)                       state_next = IDLE;
                    else if (line == LS_SE0 && !eop_seen)   eop_seen_next = 1'b1;
                    else                                    state_next = ERROR;
                end
            end
            ERROR: begin
                if (line != LS_J) begin
                    j_cnt_next = '0;
                end else if (j_cnt == J_HOLD) begin
                    state_next = IDLE;
                    j_cnt_next = '0;
                end else begin
                    j_cnt_next = j_cnt + 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        data_next   = rx_data;
        valid_next  = 1'b0;
        if (byte_done_c) begin
            data_next  = shift_next;
            valid_next = 1'b1;
        end
        start_next  = (state == SYNC) && (state_next == DATA);
        done_next   = (state == EOP) && (state_next == IDLE);
        error_next  = (state != ERROR) && (state_next == ERROR);
        active_next = (state_next == SYNC) || (state_next == DATA) || (state_next == EOP);
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            nrzi_prev       <= LS_J;
            shift           <= '0;
            bit_cnt         <= '0;
            ones_cnt        <= '0;
            eop_seen        <= 1'b0;
            j_cnt           <= '0;
            rx_data         <= '0;
            rx_data_valid   <= 1'b0;
            rx_packet_start <= 1'b0;
            rx_packet_done  <= 1'b0;
            rx_error        <= 1'b0;
            rx_active       <= 1'b0;
        end else begin
            nrzi_prev       <= nrzi_prev_next;
            shift           <= shift_next;
            bit_cnt         <= bit_cnt_next;
            ones_cnt        <= ones_cnt_next;
            eop_seen        <= eop_seen_next;
            j_cnt           <= j_cnt_next;
            rx_data         <= data_next;
            rx_data_valid   <= valid_next;
            rx_packet_start <= start_next;
            rx_packet_done  <= done_next;
            rx_error        <= error_next;
            rx_active       <= active_next;
        end
    end

endmodule

// File: tb/tb_usb_rx_decoder.sv
// Directed bench for usb_rx_decoder: NRZI line driver, pulse monitor and per-scenario checks.
module tb_usb_rx_decoder;

    localparam int unsigned CPB = 8;

    logic       clk = 1'b0;
    logic       n_rst;
    logic       dplus;
    logic       dminus;
    logic [7:0] rx_data;
    logic       rx_data_valid;
    logic       rx_packet_start;
    logic       rx_packet_done;
    logic       rx_error;
    logic       rx_active;

    usb_rx_decoder #(.CLKS_PER_BIT(CPB)) dut (
        .clk             (clk),
        .n_rst           (n_rst),
        .dplus_in        (dplus),
        .dminus_in       (dminus),
        .rx_data         (rx_data),
        .rx_data_valid   (rx_data_valid),
        .rx_packet_start (rx_packet_start),
        .rx_packet_done  (rx_packet_done),
        .rx_error        (rx_error),
        .rx_active       (rx_active)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Monitor: collects bytes and pulse counts, flags stretched pulses and active overlapping done/error.
    logic [7:0] bytes_q[$];
    int         start_cnt = 0;
    int         done_cnt  = 0;
    int         err_cnt   = 0;
    int         rule_bad  = 0;
    logic [3:0] pulses;
    logic [3:0] prev_pulses = 4'd0;

    assign pulses = {rx_data_valid, rx_packet_start, rx_packet_done, rx_error};

    always @(negedge clk) begin
        if (rx_data_valid)   bytes_q.push_back(rx_data);
        if (rx_packet_start) start_cnt++;
        if (rx_packet_done)  done_cnt++;
        if (rx_error)        err_cnt++;
        if ((rx_packet_done || rx_error) && rx_active) rule_bad++;
        if ((pulses & prev_pulses) != 4'd0) rule_bad++;
        prev_pulses = pulses;
    end

    int b_start, b_done, b_err, b_bytes;

    task automatic begin_scn();
        b_start = start_cnt;
        b_done  = done_cnt;
        b_err   = err_cnt;
        b_bytes = bytes_q.size();
    endtask

    function automatic logic [31:0] byte_at(input int idx);
        if (bytes_q.size() > idx) return 32'(bytes_q[idx]);
        return 32'hDEAD;
    endfunction

    task automatic expect_scn(input string tag, input int e_start, input int e_done, input int e_err,
                              input int e_nb, input logic [7:0] e0, input logic [7:0] e1);
        check({tag, " start"},  32'(start_cnt - b_start), 32'(e_start));
        check({tag, " done"},   32'(done_cnt - b_done),   32'(e_done));
        check({tag, " error"},  32'(err_cnt - b_err),     32'(e_err));
        check({tag, " nbytes"}, 32'(bytes_q.size() - b_bytes), 32'(e_nb));
        if (e_nb > 0) check({tag, " byte0"}, byte_at(b_bytes),     32'(e0));
        if (e_nb > 1) check({tag, " byte1"}, byte_at(b_bytes + 1), 32'(e1));
        check({tag, " active"}, 32'(rx_active), 32'd0);
    endtask

    // Line driver: J = (1,0), K = (0,1); NRZI toggles on a 0 bit.
    logic cur_dp = 1'b1;
    bit   drift  = 1'b0;
    bit   phase  = 1'b0;
    int   ones   = 0;

    task automatic put(input logic dp, input logic dm, input int n);
        dplus  = dp;
        dminus = dm;
        repeat (n) @(negedge clk);
    endtask

    task automatic tx_raw(input logic b);
        int len;
        if (!b) cur_dp = ~cur_dp;
        len = CPB;
        if (drift) begin
            len   = phase ? CPB + 1 : CPB - 1;
            phase = ~phase;
        end
        put(cur_dp, ~cur_dp, len);
    endtask

    task automatic tx_idle(input int n);
        cur_dp = 1'b1;
        put(1'b1, 1'b0, n);
    endtask

    task automatic tx_sync();
        cur_dp = 1'b1;
        phase  = 1'b0;
        for (int i = 0; i < 8; i++) tx_raw(i == 7);
        ones = 1;
    endtask

    task automatic tx_byte(input logic [7:0] b);
        for (int i = 0; i < 8; i++) begin
            tx_raw(b[i]);
            ones = b[i] ? ones + 1 : 0;
            if (ones == 6) begin
                tx_raw(1'b0);
                ones = 0;
            end
        end
    endtask

    task automatic tx_eop();
        put(1'b0, 1'b0, 2 * CPB);
        tx_idle(4 * CPB);
    endtask

    task automatic tx_nominal();
        tx_idle(2 * CPB);
        tx_sync();
        tx_byte(8'hC3);
        tx_byte(8'h5A);
        tx_eop();
    endtask

    initial begin
        n_rst  = 1'b0;
        dplus  = 1'b1;
        dminus = 1'b0;
        repeat (3) @(negedge clk);
        check("reset data", 32'(rx_data), 32'd0);
        check("reset strobes", 32'({rx_data_valid, rx_packet_start, rx_packet_done, rx_error, rx_active}), 32'd0);
        n_rst = 1'b1;
        tx_idle(3 * CPB);

        // Nominal two-byte packet.
        begin_scn();
        tx_nominal();
        expect_scn("nominal", 1, 1, 0, 2, 8'hC3, 8'h5A);
        check("data hold", 32'(rx_data), 32'h5A);

        // Bit stuffing after six 1s (SYNC's final 1 included).
        begin_scn();
        tx_idle(2 * CPB);
        tx_sync();
        tx_byte(8'hFF);
        tx_byte(8'h01);
        tx_eop();
        expect_scn("stuff", 1, 1, 0, 2, 8'hFF, 8'h01);

        // Stuff violation: SYNC 1 plus six more decoded 1s.
        begin_scn();
        tx_idle(2 * CPB);
        tx_sync();
        for (int i = 0; i < 6; i++) tx_raw(1'b1);
        tx_idle(4 * CPB);
        expect_scn("stuff_err", 1, 0, 1, 0, 8'h00, 8'h00);

        // Recovered to IDLE: a fresh packet is accepted.
        begin_scn();
        tx_nominal();
        expect_scn("post_err", 1, 1, 0, 2, 8'hC3, 8'h5A);

        // Bad SYNC KJKJKJKJ.
        begin_scn();
        tx_idle(2 * CPB);
        cur_dp = 1'b1;
        for (int i = 0; i < 8; i++) tx_raw(1'b0);
        tx_idle(4 * CPB);
        expect_scn("bad_sync", 0, 0, 1, 0, 8'h00, 8'h00);

        // Early EOP after four data bits.
        begin_scn();
        tx_idle(2 * CPB);
        tx_sync();
        tx_raw(1'b1);
        tx_raw(1'b0);
        tx_raw(1'b1);
        tx_raw(1'b1);
        tx_eop();
        expect_scn("early_eop", 1, 0, 1, 0, 8'h00, 8'h00);

        // Bit periods alternating 7/9 clocks.
        begin_scn();
        tx_idle(2 * CPB);
        drift = 1'b1;
        tx_sync();
        tx_byte(8'hC3);
        tx_byte(8'h5A);
        drift = 1'b0;
        tx_eop();
        expect_scn("drift", 1, 1, 0, 2, 8'hC3, 8'h5A);

        // Reset mid-byte drops the packet silently.
        begin_scn();
        tx_idle(2 * CPB);
        tx_sync();
        tx_raw(1'b1);
        tx_raw(1'b1);
        tx_raw(1'b0);
        check("mid active", 32'(rx_active), 32'd1);
        n_rst = 1'b0;
        #1;
        check("mid rst data", 32'(rx_data), 32'd0);
        check("mid rst strobes", 32'({rx_data_valid, rx_packet_start, rx_packet_done, rx_error, rx_active}), 32'd0);
        tx_idle(3 * CPB);
        n_rst = 1'b1;
        tx_idle(2 * CPB);
        expect_scn("rst_drop", 1, 0, 0, 0, 8'h00, 8'h00);

        begin_scn();
        tx_nominal();
        expect_scn("post_rst", 1, 1, 0, 2, 8'hC3, 8'h5A);

        check("pulse rules", 32'(rule_bad), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
